nios2_cpu_mult_unit: RTL

Parametrised, fully pipelined integer multiplier for the Nios II CPU M-stage. It generalises the three-partial-product multiply cell to any even operand width. It covers all four multiply flavours (MUL, MULH, MULHSU, MULHU) with signed correction, and a configurable pipeline depth. It accepts one operation per enabled cycle and returns the selected W-bit half of the full 2W-bit product, with a matching valid flag that the CPU uses for writeback.

---
 rtl/nios2_cpu_mult_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nios2_cpu_mult_unit.sv
// Pipelined DATA_W x DATA_W integer multiplier (MUL/MULH/MULHSU/MULHU) built from four half-width partial products.
// Latency: LATENCY enabled edges from issue to result (stage 1 partial products, stage 2 sum, then delay stages).
// Backpressure: none; M_en low freezes every register, M_flush kills all in-flight valids.
//
// Ports: clk/reset_n (async active-low), E_src1/E_src2 operands, E_mul_op select,
//        E_valid issue strobe, M_en advance enable, M_flush kill, M_mul_result/M_mul_valid output.
// DATA_W must be even and >= 8; LATENCY must be in 2..4.
module nios2_cpu_mult_unit #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] E_src1,
    input  logic [DATA_W-1:0] E_src2,
    input  logic [1:0]        E_mul_op,
    input  logic              E_valid,
    input  logic              M_en,
    input  logic              M_flush,
    output logic [DATA_W-1:0] M_mul_result,
    output logic              M_mul_valid
);

    localparam int H    = DATA_W / 2;
    localparam int W2   = 2 * DATA_W;
    localparam int NRES = LATENCY - 1;   // result stages after the partial-product stage

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // ---------------- stage 1: partial products and sign corrections ----------------
    logic [H-1:0]      a_l, a_h, b_l, b_h;
    logic              a_sgn, b_sgn;
    logic [DATA_W-1:0] pll_d, plh_d, phl_d, phh_d, ca_d, cb_d;
    logic              load1;

    logic [DATA_W-1:0] pll_q, plh_q, phl_q, phh_q, ca_q, cb_q;
    logic [1:0]        op_q;
    logic              v1_q;

    assign a_l = E_src1[H-1:0];
    assign a_h = E_src1[DATA_W-1:H];
    assign b_l = E_src2[H-1:0];
    assign b_h = E_src2[DATA_W-1:H];

    assign a_sgn = (E_mul_op == OP_MULH) || (E_mul_op == OP_MULHSU);
    assign b_sgn = (E_mul_op == OP_MULH);

    // Zero-extend each half so the product keeps its full 2H bits.
    assign pll_d = {{H{1'b0}}, a_l} * {{H{1'b0}}, b_l};
    assign plh_d = {{H{1'b0}}, a_l} * {{H{1'b0}}, b_h};
    assign phl_d = {{H{1'b0}}, a_h} * {{H{1'b0}}, b_l};
    assign phh_d = {{H{1'b0}}, a_h} * {{H{1'b0}}, b_h};

    // A negative signed operand contributes -2^W times the other (raw) operand.
    assign ca_d = (a_sgn && E_src1[DATA_W-1]) ? E_src2 : '0;
    assign cb_d = (b_sgn && E_src2[DATA_W-1]) ? E_src1 : '0;

    // Data only loads for a surviving issue, so bubbles never disturb held values.
    assign load1 = E_valid && M_en && !M_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pll_q <= '0;
            plh_q <= '0;
            phl_q <= '0;
            phh_q <= '0;
            ca_q  <= '0;
            cb_q  <= '0;
            op_q  <= OP_MUL;
            v1_q  <= 1'b0;
        end else begin
            if (load1) begin
                pll_q <= pll_d;
                plh_q <= plh_d;
                phl_q <= phl_d;
                phh_q <= phh_d;
                ca_q  <= ca_d;
                cb_q  <= cb_d;
                op_q  <= E_mul_op;
            end
            if (M_flush) begin
                v1_q <= 1'b0;
            end else if (M_en) begin
                v1_q <= E_valid;
            end
        end
    end

    // ---------------- stage 2: combine into the 2W-bit product ----------------
    logic [W2-1:0]     p_d;
    logic [DATA_W-1:0] sel_d;

    assign p_d = W2'(pll_q)
               + (W2'(plh_q) << H)
               + (W2'(phl_q) << H)
               + (W2'(phh_q) << DATA_W)
               - (W2'(ca_q)  << DATA_W)
               - (W2'(cb_q)  << DATA_W);

    assign sel_d = (op_q == OP_MUL) ? p_d[DATA_W-1:0] : p_d[W2-1:DATA_W];

    // ---------------- result stages 2..LATENCY ----------------
    // Stage 0 registers the selected half; later stages are pure delay for retiming.
    for (genvar k = 0; k < NRES; k++) begin : g_stage
        logic [DATA_W-1:0] r_q;
        logic              v_q;
        logic [DATA_W-1:0] r_d;
        logic              up_v;

        if (k == 0) begin : g_head
            assign r_d  = sel_d;
            assign up_v = v1_q;
        end else begin : g_tail
            assign r_d  = g_stage[k-1].r_q;
            assign up_v = g_stage[k-1].v_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_q <= '0;
                v_q <= 1'b0;
            end else begin
                if (M_en && up_v && !M_flush) begin
                    r_q <= r_d;
                end
                if (M_flush) begin
                    v_q <= 1'b0;
                end else if (M_en) begin
                    v_q <= up_v;
                end
            end
        end
    end

    assign M_mul_result = g_stage[NRES-1].r_q;
    assign M_mul_valid  = g_stage[NRES-1].v_q;

endmodule
